// File: rtl/evt_window_counter.sv
`default_nettype none
// ============================================================================
// evt_window_counter : per-channel event counts over a window of enabled
//                      cycles, snapshotted with a one-cycle valid strobe.
// Rev 1.0
// ============================================================================
module evt_window_counter #(
  parameter int N_CH          = 4,
  parameter int WIDTH         = 16,
  parameter int WINDOW_CYCLES = 1000,
  parameter bit SATURATE      = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [N_CH-1:0]       evt_in,
  input  logic                  en_in,
  input  logic                  clear_in,
  output logic [N_CH*WIDTH-1:0] count_out,
  output logic [N_CH-1:0]       ovf_out,
  output logic                  valid_out
);

  // A one-cycle window still needs a 1-bit timer to keep the types legal.
  localparam int               WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0]       acc_q [N_CH];
  logic [WIDTH-1:0]       acc_d [N_CH];
  logic [N_CH-1:0]        acc_ovf_q, acc_ovf_d;
  logic [N_CH*WIDTH-1:0]  count_q, count_d;
  logic [N_CH-1:0]        ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic [WIDTH-1:0]       sum [N_CH];
  logic [N_CH-1:0]        sum_ovf;
  logic                   terminal;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [WIDTH:0] raw;
      assign raw        = {1'b0, acc_q[k]} + {{WIDTH{1'b0}}, evt_in[k]};
      assign sum_ovf[k] = raw[WIDTH];
      if (SATURATE) begin : g_sat
        assign sum[k] = raw[WIDTH] ? CNT_MAX : raw[WIDTH-1:0];
      end else begin : g_wrap
        assign sum[k] = raw[WIDTH-1:0];
      end
    end
  endgenerate

  assign terminal = en_in && (win_cnt_q == WIN_LAST);

  always_comb begin
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    if (clear_in) begin
      win_cnt_d = '0;
      acc_ovf_d = '0;
      for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
    end else if (en_in) begin
      if (terminal) begin
        // Snapshot includes the terminal cycle's own events.
        for (int k = 0; k < N_CH; k++) begin
          count_d[k*WIDTH +: WIDTH] = sum[k];
          acc_d[k]                  = '0;
        end
        ovf_d     = acc_ovf_q | sum_ovf;
        acc_ovf_d = '0;
        win_cnt_d = '0;
        valid_d   = 1'b1;
      end else begin
        for (int k = 0; k < N_CH; k++) acc_d[k] = sum[k];
        acc_ovf_d = acc_ovf_q | sum_ovf;
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      win_cnt_q <= '0;
      acc_ovf_q <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_ovf_q <= acc_ovf_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign count_out = count_q;
  assign ovf_out   = ovf_q;
  assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_evt_window_counter.sv
`default_nettype none
// ============================================================================
// tb_evt_window_counter : three configurations driven in parallel and checked
//                         every cycle against a window-level event-count model.
// Rev 1.0
// ============================================================================
module tb_evt_window_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in, en_in, clear_in;
  logic [3:0] evt_in;

  logic [63:0] count_a;
  logic [15:0] count_w, count_s;
  logic [3:0]  ovf_a, ovf_w, ovf_s;
  logic        valid_a, valid_w, valid_s;

  evt_window_counter #(.N_CH(4), .WIDTH(16), .WINDOW_CYCLES(10), .SATURATE(1'b0)) dut_a (
    .clk_in(clk), .rst_in(rst_in), .evt_in(evt_in), .en_in(en_in), .clear_in(clear_in),
    .count_out(count_a), .ovf_out(ovf_a), .valid_out(valid_a));

  evt_window_counter #(.N_CH(4), .WIDTH(4), .WINDOW_CYCLES(20), .SATURATE(1'b0)) dut_w (
    .clk_in(clk), .rst_in(rst_in), .evt_in(evt_in), .en_in(en_in), .clear_in(clear_in),
    .count_out(count_w), .ovf_out(ovf_w), .valid_out(valid_w));

  evt_window_counter #(.N_CH(4), .WIDTH(4), .WINDOW_CYCLES(20), .SATURATE(1'b1)) dut_s (
    .clk_in(clk), .rst_in(rst_in), .evt_in(evt_in), .en_in(en_in), .clear_in(clear_in),
    .count_out(count_s), .ovf_out(ovf_s), .valid_out(valid_s));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per window, the true number of events seen on each
  // channel, then reduced to WIDTH bits by wrap or clamp at the snapshot.
  int c_win [3] = '{10, 20, 20};
  int c_wid [3] = '{16, 4, 4};
  bit c_sat [3] = '{1'b0, 1'b0, 1'b1};

  int m_ev  [3][4];
  int m_cyc [3];
  int m_cnt [3][4];
  bit m_ovf [3][4];
  bit m_val [3];
  bit checking = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_in) begin
        m_cyc[i] = 0;
        m_val[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          m_ev[i][k] = 0; m_cnt[i][k] = 0; m_ovf[i][k] = 1'b0;
        end
      end else if (clear_in) begin
        m_cyc[i] = 0;
        m_val[i] = 1'b0;
        for (int k = 0; k < 4; k++) m_ev[i][k] = 0;
      end else if (en_in) begin
        m_cyc[i]++;
        for (int k = 0; k < 4; k++) m_ev[i][k] += int'(evt_in[k]);
        if (m_cyc[i] == c_win[i]) begin
          int mx;
          mx = (1 << c_wid[i]) - 1;
          for (int k = 0; k < 4; k++) begin
            m_ovf[i][k] = (m_ev[i][k] > mx);
            if (c_sat[i]) m_cnt[i][k] = (m_ev[i][k] > mx) ? mx : m_ev[i][k];
            else          m_cnt[i][k] = m_ev[i][k] % (mx + 1);
            m_ev[i][k] = 0;
          end
          m_cyc[i] = 0;
          m_val[i] = 1'b1;
        end else begin
          m_val[i] = 1'b0;
        end
      end else begin
        m_val[i] = 1'b0;
      end
    end
    if (rst_in) checking = 1'b1;
  end

  function automatic int act_cnt(input int i, input int k);
    case (i)
      0:       return int'(count_a[k*16 +: 16]);
      1:       return int'(count_w[k*4 +: 4]);
      default: return int'(count_s[k*4 +: 4]);
    endcase
  endfunction

  function automatic bit act_ovf(input int i, input int k);
    case (i)
      0:       return ovf_a[k];
      1:       return ovf_w[k];
      default: return ovf_s[k];
    endcase
  endfunction

  function automatic bit act_val(input int i);
    case (i)
      0:       return valid_a;
      1:       return valid_w;
      default: return valid_s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d valid", i), 64'(act_val(i)), 64'(m_val[i]));
        for (int k = 0; k < 4; k++) begin
          check($sformatf("dut%0d ch%0d count", i, k), 64'(act_cnt(i, k)), 64'(m_cnt[i][k]));
          check($sformatf("dut%0d ch%0d ovf", i, k), 64'(act_ovf(i, k)), 64'(m_ovf[i][k]));
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic c, input logic [3:0] ev);
    @(negedge clk);
    rst_in   = r;
    en_in    = e;
    clear_in = c;
    evt_in   = ev;
  endtask

  initial begin
    rst_in = 1'b1; en_in = 1'b0; clear_in = 1'b0; evt_in = 4'h0;

    // Reset and idle with events present but enable low.
    repeat (3) drive(1, 0, 0, 4'h0);
    drive(0, 0, 0, 4'hF);
    check("reset count", count_a, 64'd0);
    check("reset ovf", 64'(ovf_a), 64'd0);
    check("reset valid", 64'(valid_a), 64'd0);
    repeat (20) drive(0, 0, 0, 4'hF);
    check("idle count", count_a, 64'd0);

    // Basic window.
    repeat (10) drive(0, 1, 0, 4'b0101);
    drive(0, 0, 0, 4'h0);
    check("basic ch0", 64'(count_a[15:0]), 64'd10);
    check("basic ch1", 64'(count_a[31:16]), 64'd0);
    check("basic ch2", 64'(count_a[47:32]), 64'd10);
    check("basic ch3", 64'(count_a[63:48]), 64'd0);
    check("basic valid", 64'(valid_a), 64'd1);

    // Event on the terminal cycle, then on the first cycle of the next window.
    repeat (9) drive(0, 1, 0, 4'h0);
    drive(0, 1, 0, 4'b0010);
    drive(0, 1, 0, 4'b0010);
    check("bound A ch1", 64'(count_a[31:16]), 64'd1);
    check("bound A valid", 64'(valid_a), 64'd1);
    repeat (9) drive(0, 1, 0, 4'h0);
    drive(0, 0, 0, 4'h0);
    check("bound B ch1", 64'(count_a[31:16]), 64'd1);
    check("bound B valid", 64'(valid_a), 64'd1);

    // Enable gap mid-window.
    repeat (4) drive(0, 1, 0, 4'b0001);
    repeat (5) drive(0, 0, 0, 4'hF);
    repeat (6) drive(0, 1, 0, 4'b0001);
    drive(0, 0, 0, 4'h0);
    check("gap ch0", 64'(count_a[15:0]), 64'd10);
    check("gap ch1", 64'(count_a[31:16]), 64'd0);
    check("gap valid", 64'(valid_a), 64'd1);

    // Clear at win_cnt=6: snapshot holds, next window is 10 enabled cycles later.
    repeat (6) drive(0, 1, 0, 4'hF);
    drive(0, 1, 1, 4'hF);
    drive(0, 1, 0, 4'b1000);
    check("clear hold ch0", 64'(count_a[15:0]), 64'd10);
    check("clear valid", 64'(valid_a), 64'd0);
    repeat (8) drive(0, 1, 0, 4'b1000);
    drive(0, 1, 0, 4'b1000);
    check("clear early valid", 64'(valid_a), 64'd0);
    drive(0, 0, 0, 4'h0);
    check("clear ch3", 64'(count_a[63:48]), 64'd10);
    check("clear ch0", 64'(count_a[15:0]), 64'd0);
    check("clear next valid", 64'(valid_a), 64'd1);

    // Overflow on the 4-bit configurations.
    drive(1, 0, 0, 4'h0);
    repeat (20) drive(0, 1, 0, 4'b0001);
    drive(0, 0, 0, 4'h0);
    check("wrap count", 64'(count_w[3:0]), 64'd4);
    check("wrap ovf", 64'(ovf_w[0]), 64'd1);
    check("sat count", 64'(count_s[3:0]), 64'd15);
    check("sat ovf", 64'(ovf_s[0]), 64'd1);
    repeat (17) drive(0, 1, 0, 4'h0);
    repeat (3) drive(0, 1, 0, 4'b0001);
    drive(0, 0, 0, 4'h0);
    check("wrap next count", 64'(count_w[3:0]), 64'd3);
    check("wrap next ovf", 64'(ovf_w[0]), 64'd0);
    check("sat next count", 64'(count_s[3:0]), 64'd3);
    check("sat next ovf", 64'(ovf_s[0]), 64'd0);
    check("pre-reset ch0", 64'(count_a[15:0]), 64'd3);

    // Reset mid-window at win_cnt=7.
    repeat (7) drive(0, 1, 0, 4'b0001);
    drive(1, 0, 0, 4'h0);
    drive(0, 1, 0, 4'b0001);
    check("midrst count", count_a, 64'd0);
    check("midrst valid", 64'(valid_a), 64'd0);
    repeat (8) drive(0, 1, 0, 4'b0001);
    drive(0, 1, 0, 4'b0001);
    check("midrst early valid", 64'(valid_a), 64'd0);
    drive(0, 0, 0, 4'h0);
    check("midrst ch0", 64'(count_a[15:0]), 64'd10);
    check("midrst valid", 64'(valid_a), 64'd1);

    // Randomized traffic with alternating event density.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ev;
      int dens;
      dens = ((n / 250) % 2 == 0) ? 5 : 9;
      for (int b = 0; b < 4; b++) ev[b] = ($urandom_range(0, 9) < dens);
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 8,
            $urandom_range(0, 79) == 0, ev);
    end
    drive(0, 0, 0, 4'h0);
    drive(0, 0, 0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
